// File: rtl/pll_rst_pkg.sv
// Shared types, default parameters and the counter-width helper for the
// PLL reset sequencer.
package pll_rst_pkg;

   // Sequencer states.
   typedef enum logic [2:0] {
      PLL_RESET = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4
   } pll_rst_state_t;

   // Default parameter values (50 MHz reference clock).
   localparam int DEF_NUM_RESETS     = 3;
   localparam int DEF_SYNC_STAGES    = 2;
   localparam int DEF_PLL_RST_CYCLES = 16;
   localparam int DEF_LOCK_TIMEOUT   = 50000;
   localparam int DEF_STABLE_CYCLES  = 1024;
   localparam int DEF_STAGE_GAP      = 64;
   localparam int DEF_RETRY_W        = 8;

   // Width of the shared state counter: must hold the largest terminal count
   // used in any state so that it never wraps.
   function automatic int cnt_width(input int lock_timeout,
                                    input int stable_cycles,
                                    input int num_resets,
                                    input int stage_gap,
                                    input int pll_rst_cycles);
      int m;
      m = lock_timeout;
      if (stable_cycles > m) m = stable_cycles;
      if ((num_resets * stage_gap + stage_gap) > m) m = num_resets * stage_gap + stage_gap;
      if (pll_rst_cycles > m) m = pll_rst_cycles;
      if (m < 2) return 1;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// N-flop synchronizer with synchronous clear for a single asynchronous bit.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff_r;

   // Shift the asynchronous input through the flop chain; clear forces all zeros.
   always_ff @(posedge clk) begin
      if (clr) begin
         ff_r <= '0;
      end else begin
         ff_r <= {ff_r[STAGES-2:0], d};
      end
   end

   assign q = ff_r[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for the system PLL: pulses the PLL reset, waits for a stable
// lock, then releases the domain resets one by one; restarts on lock loss or
// lock timeout. Runs entirely on the free-running reference clock.
module pll_reset_sequencer
   import pll_rst_pkg::*;
#(
   parameter int NUM_RESETS     = DEF_NUM_RESETS,
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int STAGE_GAP      = DEF_STAGE_GAP,
   parameter int RETRY_W        = DEF_RETRY_W
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  locked,
   output logic                  pll_rst,
   output logic [NUM_RESETS-1:0] rst_out,
   output logic                  all_ready,
   output logic                  lock_lost,
   output logic [RETRY_W-1:0]    retry_count
);

   localparam int CNT_W = cnt_width(LOCK_TIMEOUT, STABLE_CYCLES, NUM_RESETS,
                                    STAGE_GAP, PLL_RST_CYCLES);

   pll_rst_state_t        state_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [CNT_W-1:0]      cnt_nxt_s;
   logic [NUM_RESETS-1:0] rst_out_r;
   logic [NUM_RESETS-1:0] release_mask_s;
   logic                  pll_rst_r;
   logic                  all_ready_r;
   logic                  lock_lost_r;
   logic [RETRY_W-1:0]    retry_r;
   logic                  locked_s;
   logic                  lose_s;

   sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk (refclk),
      .clr (rst),
      .d   (locked),
      .q   (locked_s)
   );

   // Next count and the staged release mask: bit i is released once the
   // RELEASE count reaches i*STAGE_GAP, so bits can only release in order.
   always_comb begin
      cnt_nxt_s      = cnt_r + CNT_W'(1);
      release_mask_s = '1;
      release_mask_s[0] = 1'b0;
      for (int i = 1; i < NUM_RESETS; i++) begin
         if (cnt_nxt_s >= CNT_W'(i * STAGE_GAP)) begin
            release_mask_s[i] = 1'b0;
         end else begin
            release_mask_s[i] = 1'b1;
         end
      end
      if (!locked_s && ((state_r == RELEASE) || (state_r == RUN))) begin
         lose_s = 1'b1;
      end else begin
         lose_s = 1'b0;
      end
   end

   // Sequencer FSM with registered outputs; lock loss outranks any stage boundary.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_r     <= PLL_RESET;
         cnt_r       <= '0;
         pll_rst_r   <= 1'b1;
         rst_out_r   <= '1;
         all_ready_r <= 1'b0;
         lock_lost_r <= 1'b0;
         retry_r     <= '0;
      end else if (lose_s) begin
         state_r     <= PLL_RESET;
         cnt_r       <= '0;
         pll_rst_r   <= 1'b1;
         rst_out_r   <= '1;
         all_ready_r <= 1'b0;
         lock_lost_r <= 1'b1;
      end else begin
         lock_lost_r <= 1'b0;
         case (state_r)
            PLL_RESET: begin
               pll_rst_r <= 1'b1;
               if (cnt_r == CNT_W'(PLL_RST_CYCLES - 1)) begin
                  state_r   <= WAIT_LOCK;
                  cnt_r     <= '0;
                  pll_rst_r <= 1'b0;
               end else begin
                  cnt_r <= cnt_nxt_s;
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state_r <= STABILIZE;
                  cnt_r   <= '0;
               end else if (cnt_r == CNT_W'(LOCK_TIMEOUT - 1)) begin
                  state_r   <= PLL_RESET;
                  cnt_r     <= '0;
                  pll_rst_r <= 1'b1;
                  if (retry_r != {RETRY_W{1'b1}}) begin
                     retry_r <= retry_r + RETRY_W'(1);
                  end
               end else begin
                  cnt_r <= cnt_nxt_s;
               end
            end
            STABILIZE: begin
               if (!locked_s) begin
                  state_r <= WAIT_LOCK;
                  cnt_r   <= '0;
               end else if (cnt_r == CNT_W'(STABLE_CYCLES - 1)) begin
                  state_r      <= RELEASE;
                  cnt_r        <= '0;
                  rst_out_r[0] <= 1'b0;
               end else begin
                  cnt_r <= cnt_nxt_s;
               end
            end
            RELEASE: begin
               if (cnt_nxt_s == CNT_W'(NUM_RESETS * STAGE_GAP)) begin
                  state_r     <= RUN;
                  cnt_r       <= '0;
                  rst_out_r   <= '0;
                  all_ready_r <= 1'b1;
               end else begin
                  cnt_r     <= cnt_nxt_s;
                  rst_out_r <= rst_out_r & release_mask_s;
               end
            end
            RUN: begin
               cnt_r <= '0;
            end
            default: begin
               state_r     <= PLL_RESET;
               cnt_r       <= '0;
               pll_rst_r   <= 1'b1;
               rst_out_r   <= '1;
               all_ready_r <= 1'b0;
            end
         endcase
      end
   end

   assign pll_rst     = pll_rst_r;
   assign rst_out     = rst_out_r;
   assign all_ready   = all_ready_r;
   assign lock_lost   = lock_lost_r;
   assign retry_count = retry_r;

endmodule
